fp_normalize_round: RTL

//  Post-add stage of the single-precision FP adder, after mantissa alignment and add/sub.

---
 rtl/fp_normalize_round.sv | 105 ++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: iterative normalize, round-to-nearest-even and pack stage of an FP32 adder
module fp_normalize_round (
   input  logic        clk,
   input  logic        rst,
   input  logic        inValid,
   output logic        inReady,
   input  logic        sign,
   input  logic [7:0]  exponent,
   input  logic [27:0] sumMant,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);
   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
   state_t state, state_n;
   logic [27:0] m, m_n;
   logic [8:0] e, e_n, e_inc;
   logic s, s_n, ovf_n, unf_n, round_up;
   logic [31:0] res_n;
   logic [24:0] mr;
   assign inReady  = state == IDLE;
   assign outValid = state == DONE;
   assign e_inc    = e + 9'd1;
   // ties go up only when the kept lsb is odd
   assign round_up = m[2] & (m[1] | m[0] | m[3]);
   assign mr       = {1'b0, m[26:3]} + {24'd0, round_up};
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         m         <= '0;
         e         <= '0;
         s         <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_n;
         m         <= m_n;
         e         <= e_n;
         s         <= s_n;
         result    <= res_n;
         overflow  <= ovf_n;
         underflow <= unf_n;
      end
   end
   always_comb begin
      state_n = state;
      m_n     = m;
      e_n     = e;
      s_n     = s;
      res_n   = result;
      ovf_n   = overflow;
      unf_n   = underflow;
      case (state)
         IDLE: if (inValid) begin
            s_n   = sign;
            e_n   = {1'b0, exponent};
            m_n   = sumMant;
            ovf_n = 1'b0;
            unf_n = 1'b0;
            if (sumMant == 28'd0) begin
               res_n   = 32'h0000_0000;
               state_n = DONE;
            end else if (exponent == 8'hFF) begin
               res_n   = {sign, 8'hFF, 23'h0};
               ovf_n   = 1'b1;
               state_n = DONE;
            end else
               state_n = NORM;
         end
         NORM: if (m[27]) begin
            m_n = {1'b0, m[27:2], m[1] | m[0]};
            e_n = e_inc;
            if (e_inc == 9'd255) begin
               res_n   = {s, 8'hFF, 23'h0};
               ovf_n   = 1'b1;
               state_n = DONE;
            end else
               state_n = ROUND;
         end else if (m[26])
            state_n = ROUND;
         else if (e <= 9'd1) begin
            res_n   = {s, 31'h0};
            unf_n   = 1'b1;
            state_n = DONE;
         end else begin
            m_n = {m[26:0], 1'b0};
            e_n = e - 9'd1;
         end
         ROUND: begin
            if (mr[24]) begin
               e_n   = e_inc;
               ovf_n = e_inc == 9'd255;
               res_n = (e_inc == 9'd255) ? {s, 8'hFF, 23'h0} : {s, e_inc[7:0], mr[23:1]};
            end else
               res_n = {s, e[7:0], mr[22:0]};
            state_n = DONE;
         end
         DONE: if (outReady) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule
